// File: rtl/instr_sequencer.sv
// Instruction sequencer: program counter with relative jump, call/return stack
// and sticky overflow/underflow halt. Define SEQ_WRAP_STACK_EN for a circular return stack.
module instr_sequencer #(
  parameter int WORD_WIDTH   = 16,
  parameter int OFFSET_WIDTH = 8,
  parameter int STACK_DEPTH  = 8,
  parameter logic [WORD_WIDTH-1:0] RESET_ADDR = {WORD_WIDTH{1'b0}}
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             advance,
  input  logic [1:0]                       op,
  input  logic                             cond,
  input  logic [OFFSET_WIDTH-1:0]          offset,
  output logic [WORD_WIDTH-1:0]            pointer,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
  output logic                             overflow,
  output logic                             underflow,
  output logic                             halted
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [WORD_WIDTH-1:0] ONE_W      = WORD_WIDTH'(1'b1);
  localparam logic [DW-1:0]         ONE_D      = DW'(1'b1);
  localparam logic [DW-1:0]         ZERO_D     = {DW{1'b0}};
  localparam logic [DW-1:0]         DEPTH_FULL = DW'(STACK_DEPTH);
  localparam logic [IW-1:0]         ONE_I      = IW'(1'b1);
  localparam logic [IW-1:0]         ZERO_I     = {IW{1'b0}};
  localparam logic [IW-1:0]         IDX_LAST   = IW'(STACK_DEPTH - 1);

  typedef enum logic [1:0] {
    OP_NEXT = 2'b00,
    OP_JUMP = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_e;

  function automatic logic [WORD_WIDTH-1:0] sext(input logic [OFFSET_WIDTH-1:0] v);
    return WORD_WIDTH'($signed(v));
  endfunction

  // Stack slots are addressed circularly so the same indexing serves both stack modes.
  function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
    if (i == IDX_LAST) return ZERO_I;
    else               return i + ONE_I;
  endfunction

  function automatic logic [IW-1:0] idx_dec(input logic [IW-1:0] i);
    if (i == ZERO_I) return IDX_LAST;
    else             return i - ONE_I;
  endfunction

  logic [WORD_WIDTH-1:0] pointer_r;
  logic [WORD_WIDTH-1:0] ptr_nxt_s;
  logic [WORD_WIDTH-1:0] seq_ptr_s;
  logic [WORD_WIDTH-1:0] tgt_ptr_s;
  logic [WORD_WIDTH-1:0] stack_r [STACK_DEPTH];
  logic [DW-1:0]         depth_r;
  logic [DW-1:0]         depth_nxt_s;
  logic [IW-1:0]         wr_idx_r;
  logic [IW-1:0]         wr_idx_nxt_s;
  logic [IW-1:0]         top_idx_s;
  logic                  push_s;
  logic                  ovf_set_s;
  logic                  unf_set_s;
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  halted_r;

  assign seq_ptr_s = pointer_r + ONE_W;
  assign tgt_ptr_s = pointer_r + sext(offset);
  assign top_idx_s = idx_dec(wr_idx_r);

  // Decode the requested operation into next pointer, stack motion and fault flags.
  always_comb begin
    ptr_nxt_s    = pointer_r;
    depth_nxt_s  = depth_r;
    wr_idx_nxt_s = wr_idx_r;
    push_s       = 1'b0;
    ovf_set_s    = 1'b0;
    unf_set_s    = 1'b0;
    if (advance && !halted_r) begin
      case (op_e'(op))
        OP_NEXT: ptr_nxt_s = seq_ptr_s;
        OP_JUMP: begin
          if (cond) ptr_nxt_s = tgt_ptr_s;
          else      ptr_nxt_s = seq_ptr_s;
        end
        OP_CALL: begin
          if (!cond) begin
            ptr_nxt_s = seq_ptr_s;
          end else if (depth_r != DEPTH_FULL) begin
            push_s       = 1'b1;
            depth_nxt_s  = depth_r + ONE_D;
            wr_idx_nxt_s = idx_inc(wr_idx_r);
            ptr_nxt_s    = tgt_ptr_s;
          end else begin
`ifdef SEQ_WRAP_STACK_EN
            // Full stack: the write slot is the oldest entry, so it is overwritten.
            push_s       = 1'b1;
            wr_idx_nxt_s = idx_inc(wr_idx_r);
            ptr_nxt_s    = tgt_ptr_s;
`else
            ovf_set_s    = 1'b1;
`endif
          end
        end
        OP_RET: begin
          if (!cond) begin
            ptr_nxt_s = seq_ptr_s;
          end else if (depth_r != ZERO_D) begin
            ptr_nxt_s    = stack_r[top_idx_s];
            depth_nxt_s  = depth_r - ONE_D;
            wr_idx_nxt_s = top_idx_s;
          end else begin
            unf_set_s    = 1'b1;
          end
        end
        default: ptr_nxt_s = pointer_r;
      endcase
    end else begin
      ptr_nxt_s = pointer_r;
    end
  end

  // Pointer, stack bookkeeping and sticky fault registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pointer_r   <= RESET_ADDR;
      depth_r     <= ZERO_D;
      wr_idx_r    <= ZERO_I;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      pointer_r   <= ptr_nxt_s;
      depth_r     <= depth_nxt_s;
      wr_idx_r    <= wr_idx_nxt_s;
      overflow_r  <= overflow_r | ovf_set_s;
      underflow_r <= underflow_r | unf_set_s;
      halted_r    <= halted_r | ovf_set_s | unf_set_s;
    end
  end

  // Return-stack storage; a push records the return address pointer+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack_r[i] <= {WORD_WIDTH{1'b0}};
    end else if (push_s) begin
      stack_r[wr_idx_r] <= seq_ptr_s;
    end
  end

  assign pointer   = pointer_r;
  assign depth     = depth_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;
  assign halted    = halted_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer (STACK_DEPTH=2): directed cases plus random ops
// checked against a queue-based reference model.
module tb_instr_sequencer;

  localparam int SD = 2;
  localparam logic [15:0] RA = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        advance = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        cond = 1'b0;
  logic [7:0]  offset = 8'h00;
  logic [15:0] pointer;
  logic [1:0]  depth;
  logic        overflow, underflow, halted;

  instr_sequencer #(.WORD_WIDTH(16), .OFFSET_WIDTH(8), .STACK_DEPTH(SD), .RESET_ADDR(RA)) dut (
    .clk(clk), .rst_n(rst_n), .advance(advance), .op(op), .cond(cond), .offset(offset),
    .pointer(pointer), .depth(depth), .overflow(overflow), .underflow(underflow), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] ptr;
    logic [1:0]  dep;
    logic        ovf;
    logic        unf;
    logic        hlt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference model: pointer as an integer, return stack as a queue (back = top).
  int m_ptr;
  int m_stack[$];
  bit m_ovf, m_unf;

  function automatic void model_reset();
    m_ptr = int'(RA);
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endfunction

  function automatic void model_apply(bit adv, bit [1:0] o, bit c, bit [7:0] off);
    int s, tgt, nxt;
    if (!adv || m_ovf || m_unf) return;
    s   = off[7] ? int'(off) - 256 : int'(off);
    tgt = (m_ptr + s) & 32'h0000_FFFF;
    nxt = (m_ptr + 1) & 32'h0000_FFFF;
    if (o == 2'd0) m_ptr = nxt;
    else if (o == 2'd1) m_ptr = c ? tgt : nxt;
    else if (o == 2'd2) begin
      if (!c) m_ptr = nxt;
      else if (m_stack.size() < SD) begin
        m_stack.push_back(nxt);
        m_ptr = tgt;
      end else begin
`ifdef SEQ_WRAP_STACK_EN
        void'(m_stack.pop_front());
        m_stack.push_back(nxt);
        m_ptr = tgt;
`else
        m_ovf = 1'b1;
`endif
      end
    end else begin
      if (!c) m_ptr = nxt;
      else if (m_stack.size() > 0) m_ptr = m_stack.pop_back();
      else m_unf = 1'b1;
    end
  endfunction

  function automatic exp_t model_state();
    exp_t e;
    e.ptr = 16'(m_ptr);
    e.dep = 2'(m_stack.size());
    e.ovf = m_ovf;
    e.unf = m_unf;
    e.hlt = m_ovf | m_unf;
    return e;
  endfunction

  function automatic void compare(string name, exp_t act, exp_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got ptr=%h depth=%0d ovf=%b unf=%b halt=%b, want ptr=%h depth=%0d ovf=%b unf=%b halt=%b",
               name, $time, act.ptr, act.dep, act.ovf, act.unf, act.hlt,
               exp.ptr, exp.dep, exp.ovf, exp.unf, exp.hlt);
    end
  endfunction

  function automatic exp_t dut_state();
    exp_t a;
    a.ptr = pointer;
    a.dep = depth;
    a.ovf = overflow;
    a.unf = underflow;
    a.hlt = halted;
    return a;
  endfunction

  // Monitor: after every rising edge, consume one pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        compare("cycle", dut_state(), e);
      end
    end
  end

  task automatic step(bit adv, bit [1:0] o, bit c, bit [7:0] off);
    @(negedge clk);
    advance = adv;
    op      = o;
    cond    = c;
    offset  = off;
    model_apply(adv, o, c, off);
    sb.push_back(model_state());
  endtask

  // Reset pulsed mid-cycle while a taken CALL is being presented.
  task automatic do_reset();
    exp_t zero;
    @(negedge clk);
    advance = 1'b1;
    op      = 2'b10;
    cond    = 1'b1;
    offset  = 8'($urandom_range(0, 255));
    #2 rst_n = 1'b0;
    #1;
    zero = '{ptr: RA, dep: 2'd0, ovf: 1'b0, unf: 1'b0, hlt: 1'b0};
    compare("async_reset", dut_state(), zero);
    model_reset();
    sb.push_back(model_state());
    @(negedge clk);
    rst_n   = 1'b1;
    advance = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();
    // Sequential steps from reset
    step(1, 2'd0, 0, 8'h00);
    step(1, 2'd0, 1, 8'h55);
    step(1, 2'd0, 0, 8'h00);
    step(0, 2'd1, 1, 8'h40);
    // Relative jumps backward and not-taken
    do_reset();
    step(1, 2'd1, 1, 8'h10);
    step(1, 2'd1, 1, 8'hFE);
    step(1, 2'd1, 0, 8'h33);
    // Wrap-around at the top and large negative offset
    do_reset();
    step(1, 2'd1, 1, 8'hFF);
    step(1, 2'd0, 0, 8'h00);
    do_reset();
    step(1, 2'd0, 0, 8'h00);
    step(1, 2'd0, 0, 8'h00);
    step(1, 2'd1, 1, 8'h80);
    // Call and immediate return
    do_reset();
    step(1, 2'd1, 1, 8'h20);
    step(1, 2'd2, 1, 8'h10);
    step(1, 2'd3, 1, 8'h00);
    step(1, 2'd2, 0, 8'h10);
    step(1, 2'd3, 0, 8'h00);
    // Fill the stack past its depth, then try to unwind
    step(1, 2'd2, 1, 8'h05);
    step(1, 2'd2, 1, 8'h05);
    step(1, 2'd2, 1, 8'h05);
    step(1, 2'd0, 0, 8'h00);
    step(1, 2'd1, 1, 8'h07);
    step(1, 2'd3, 1, 8'h00);
    step(1, 2'd3, 1, 8'h00);
    step(1, 2'd3, 1, 8'h00);
    step(1, 2'd0, 0, 8'h00);
    // Return with empty stack
    do_reset();
    step(1, 2'd3, 1, 8'h00);
    step(1, 2'd0, 0, 8'h00);
    do_reset();
    // Random operations
    for (int i = 0; i < 1500; i++) begin
      if ((m_ovf || m_unf) && $urandom_range(0, 5) == 0) do_reset();
      else step($urandom_range(0, 9) < 8, 2'($urandom_range(0, 3)),
                $urandom_range(0, 9) < 7, 8'($urandom_range(0, 255)));
    end
    @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Parametrised successor to the fixed-width instruction pointer: holds the program counter and drives it on each advance strobe from control.
- Supports sequential step, conditional signed-relative jump, conditional call and conditional return, using a hardware return stack of configurable depth.
- Sits between control (advance, op) and decode (offset, cond). Its pointer output feeds instruction fetch.
- Detects stack overflow and underflow as a sticky fault that halts sequencing until reset.

Parameters:
- WORD_WIDTH, 16, width of pointer and of return-stack entries.
- OFFSET_WIDTH, 8, width of the signed relative offset from decode (OFFSET_WIDTH <= WORD_WIDTH).
- STACK_DEPTH, 8, number of return-stack entries (>= 1).
- RESET_ADDR, 0, pointer value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- advance  in  1  one-cycle strobe: perform op this cycle.
- op  in  2  operation: 00 NEXT, 01 JUMP, 10 CALL, 11 RET.
- cond  in  1  condition gate for JUMP/CALL/RET; ignored for NEXT.
- offset  in  OFFSET_WIDTH  signed two's-complement displacement.
- pointer  out  WORD_WIDTH  current instruction address (registered).
- depth  out  $clog2(STACK_DEPTH+1)  number of valid return-stack entries.
- overflow  out  1  sticky: CALL attempted with stack full.
- underflow  out  1  sticky: RET attempted with stack empty.
- halted  out  1  overflow | underflow.

Behaviour:
- Reset: asynchronous on rst_n low, one clock, as already decided. pointer=RESET_ADDR, depth=0, overflow=0, underflow=0, halted=0. Stack contents are don't-care.
- All updates occur on the rising clk edge where advance=1 and halted=0. Otherwise every state element holds.
- sext(offset) sign-extends offset to WORD_WIDTH. All pointer arithmetic is modulo 2^WORD_WIDTH (wraps silently).
- NEXT: pointer <= pointer+1.
- JUMP, cond=1: pointer <= pointer+sext(offset).
- JUMP, cond=0: pointer <= pointer+1.
- CALL, cond=1, depth<STACK_DEPTH: push pointer+1, depth+1, pointer <= pointer+sext(offset).
- CALL, cond=1, depth==STACK_DEPTH: overflow<=1. pointer and depth unchanged.
- CALL, cond=0: behaves as NEXT; no push.
- RET, cond=1, depth>0: pointer <= top entry, pop, depth-1.
- RET, cond=1, depth==0: underflow<=1. pointer unchanged.
- RET, cond=0: behaves as NEXT.
- Latency: the new pointer is visible the cycle after the advance edge. Back-to-back advance is allowed every cycle; CALL followed immediately by RET returns to the call site+1.
- Stack is LIFO. Top entry means the most recently pushed one.
- Faults are sticky until rst_n. While halted, advance is ignored; pointer holds the faulting instruction's address.
- Reset asserted mid-operation aborts it. No partial push or pop survives.
- offset is don't-care for NEXT and RET.

Optional Feature:
- Macro: SEQ_WRAP_STACK_EN.
- Defined: the stack is a circular buffer. A CALL when full overwrites the oldest entry, depth stays STACK_DEPTH, overflow never sets, and the jump proceeds normally. RET-on-empty still sets underflow.
- Undefined: overflow behaviour as in Behaviour (fault and halt).

Test Plan:
- Reset release, three NEXT advances -> pointer 0,1,2,3; depth 0; no flags.
- pointer=0x0010, JUMP cond=1 offset=0xFE -> 0x000E. JUMP cond=0 -> 0x000F.
- pointer=0xFFFF, NEXT -> 0x0000. pointer=0x0002, JUMP offset=0x80 -> 0xFF82.
- pointer=0x0020, CALL offset=0x10 -> pointer 0x0030, depth 1. RET -> pointer 0x0021, depth 0.
- STACK_DEPTH=2: three taken CALLs -> third sets overflow/halted, pointer frozen, depth 2. Subsequent advances ignored. With SEQ_WRAP_STACK_EN, there is no fault and three RETs set underflow on the third.
- RET cond=1 at depth 0 -> underflow=1, halted=1. Pulse rst_n low mid-cycle -> immediate pointer=RESET_ADDR, flags clear.
